// File: rtl/matrix_stream_loader_if.sv
// Byte-stream in, element write port out, and the ACK/NAK response port of the
// matrix stream loader. master = loader side, slave = UART/buffer side.
interface matrix_stream_loader_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic              mem_sel;
    logic [7:0]        mem_row;
    logic [7:0]        mem_col;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        m_dim;
    logic [7:0]        n_dim;
    logic [7:0]        p_dim;
    logic              busy;
    logic              load_done;
    logic [1:0]        err_code;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output mem_we, mem_sel, mem_row, mem_col, mem_wdata,
               m_dim, n_dim, p_dim, busy, load_done, err_code, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  mem_we, mem_sel, mem_row, mem_col, mem_wdata,
               m_dim, n_dim, p_dim, busy, load_done, err_code, tx_data, tx_valid
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// Parses a framed UART byte stream (sync, M/N/P, A, B, XOR checksum) into
// operand-buffer writes and answers each frame with an ACK or NAK byte.
module matrix_stream_loader #(
    parameter int MAX_M          = 4,
    parameter int MAX_N          = 4,
    parameter int MAX_P          = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_stream_loader_if.master bus
);
    localparam int BPW = DATA_W / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef enum logic [2:0] {IDLE, DIMS, LOAD_A, LOAD_B, CHECK, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        dim_idx_q, dim_idx_d;
    logic [7:0]        m_q, m_d, n_q, n_d, p_q, p_d;
    logic [7:0]        row_q, row_d, col_q, col_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d, mem_sel_q, mem_sel_d;
    logic [7:0]        mem_row_q, mem_row_d, mem_col_q, mem_col_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        m_dim_q, m_dim_d, n_dim_q, n_dim_d, p_dim_q, p_dim_d;
    logic              busy_q, busy_d, tx_valid_q, tx_valid_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic [DATA_W-1:0] word_next;
    logic [TW-1:0]     tmo_inc;
    logic [7:0]        last_row, last_col;

    always_comb begin
        state_d     = state_q;
        dim_idx_d   = dim_idx_q;
        m_d         = m_q;
        n_d         = n_q;
        p_d         = p_q;
        row_d       = row_q;
        col_d       = col_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_row_d   = mem_row_q;
        mem_col_d   = mem_col_q;
        mem_wdata_d = mem_wdata_q;
        m_dim_d     = m_dim_q;
        n_dim_d     = n_dim_q;
        p_dim_d     = p_dim_q;
        busy_d      = busy_q;
        err_d       = err_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;

        word_next = (word_q << 8) | DATA_W'(bus.rx_data);
        tmo_inc   = tmo_q + 1'b1;
        last_col  = (state_q == LOAD_A) ? n_q - 8'd1 : p_q - 8'd1;
        last_row  = (state_q == LOAD_A) ? m_q - 8'd1 : n_q - 8'd1;

        // Timeout only advances on idle cycles, so a byte on the firing cycle wins.
        if (state_q inside {DIMS, LOAD_A, LOAD_B, CHECK}) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_inc;
                if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                    state_d    = RESP;
                    tx_data_d  = NAK;
                    tx_valid_d = 1'b1;
                    err_d      = 2'd3;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC) begin
                    state_d   = DIMS;
                    dim_idx_d = 2'd0;
                    csum_d    = 8'd0;
                    err_d     = 2'd0;
                    busy_d    = 1'b1;
                    tmo_d     = '0;
                end
            end
            DIMS: begin
                if (bus.rx_valid) begin
                    csum_d    = csum_q ^ bus.rx_data;
                    dim_idx_d = dim_idx_q + 2'd1;
                    case (dim_idx_q)
                        2'd0:    m_d = bus.rx_data;
                        2'd1:    n_d = bus.rx_data;
                        default: begin
                            p_d = bus.rx_data;
                            if (m_q == 8'd0 || m_q > 8'(MAX_M) ||
                                n_q == 8'd0 || n_q > 8'(MAX_N) ||
                                bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_P)) begin
                                state_d    = RESP;
                                tx_data_d  = NAK;
                                tx_valid_d = 1'b1;
                                err_d      = 2'd1;
                            end else begin
                                state_d    = LOAD_A;
                                row_d      = 8'd0;
                                col_d      = 8'd0;
                                byte_cnt_d = '0;
                                word_d     = '0;
                            end
                        end
                    endcase
                end
            end
            LOAD_A, LOAD_B: begin
                if (bus.rx_valid) begin
                    csum_d = csum_q ^ bus.rx_data;
                    word_d = word_next;
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d  = '0;
                        mem_we_d    = 1'b1;
                        mem_sel_d   = (state_q == LOAD_B);
                        mem_row_d   = row_q;
                        mem_col_d   = col_q;
                        mem_wdata_d = word_next;
                        if (col_q == last_col) begin
                            col_d = 8'd0;
                            if (row_q == last_row) begin
                                row_d   = 8'd0;
                                state_d = (state_q == LOAD_A) ? LOAD_B : CHECK;
                            end else begin
                                row_d = row_q + 8'd1;
                            end
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    state_d    = RESP;
                    tx_valid_d = 1'b1;
                    if (bus.rx_data == csum_q) begin
                        tx_data_d = ACK;
                    end else begin
                        tx_data_d = NAK;
                        err_d     = 2'd2;
                    end
                end
            end
            RESP: begin
                if (bus.tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    if (tx_data_q == ACK) begin
                        m_dim_d = m_q;
                        n_dim_d = n_q;
                        p_dim_d = p_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dim_idx_q   <= '0;
            m_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_row_q   <= '0;
            mem_col_q   <= '0;
            mem_wdata_q <= '0;
            m_dim_q     <= '0;
            n_dim_q     <= '0;
            p_dim_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dim_idx_q   <= dim_idx_d;
            m_q         <= m_d;
            n_q         <= n_d;
            p_q         <= p_d;
            row_q       <= row_d;
            col_q       <= col_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_row_q   <= mem_row_d;
            mem_col_q   <= mem_col_d;
            mem_wdata_q <= mem_wdata_d;
            m_dim_q     <= m_dim_d;
            n_dim_q     <= n_dim_d;
            p_dim_q     <= p_dim_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_row   = mem_row_q;
    assign bus.mem_col   = mem_col_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.m_dim     = m_dim_q;
    assign bus.n_dim     = n_dim_q;
    assign bus.p_dim     = p_dim_q;
    assign bus.busy      = busy_q;
    assign bus.err_code  = err_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    // Must coincide with the accept cycle, so it follows tx_ready combinationally.
    assign bus.load_done = (state_q == RESP) && tx_valid_q && bus.tx_ready && (tx_data_q == ACK);
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: DATA_W=32, MAX 4x4x4, 100-cycle timeout.
module tb_matrix_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_stream_loader_if #(.DATA_W(32)) bus ();

    matrix_stream_loader #(
        .MAX_M(4), .MAX_N(4), .MAX_P(4), .DATA_W(32), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int ld_cnt = 0;
    int txv_rise = 0;
    logic txv_prev = 1'b0;
    logic [63:0] wr_log[$];
    logic [7:0]  fr[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] wr(input logic sel, input logic [7:0] r, input logic [7:0] c,
                                       input logic [31:0] d);
        return {15'd0, sel, r, c, d};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) wr_log.push_back({15'd0, bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata});
        if (bus.load_done) ld_cnt <= ld_cnt + 1;
        if (bus.tx_valid && !txv_prev) txv_rise <= txv_rise + 1;
        txv_prev <= bus.tx_valid;
    end

    // Frame with A/B elements numbered 1,2,3,... in stream order; checksum hand-supplied.
    task automatic build(input int m, input int n, input int p, input logic [7:0] cs);
        logic [31:0] v;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(m));
        fr.push_back(8'(n));
        fr.push_back(8'(p));
        for (int k = 0; k < m*n + n*p; k++) begin
            v = 32'(k + 1);
            fr.push_back(v[31:24]);
            fr.push_back(v[23:16]);
            fr.push_back(v[15:8]);
            fr.push_back(v[7:0]);
        end
        fr.push_back(cs);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send(fr[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, l0, r0, waits;
        logic stable;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst = 1'b1;
        idle(3);
        chk("rst_wrport", {bus.mem_we, bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata}, 64'd0);
        chk("rst_status", {bus.m_dim, bus.n_dim, bus.p_dim, bus.busy, bus.load_done, bus.err_code,
                           bus.tx_data, bus.tx_valid}, 64'd0);
        rst = 1'b0;
        idle(1);

        // junk before sync is ignored
        send(8'h00);
        send(8'h11);
        idle(3);
        chk("junk_busy", bus.busy, 0);
        chk("junk_writes", wr_log.size(), 0);

        // good frame 2x3x2, A=1..6, B=7..12
        build(2, 3, 2, 8'h0F);
        send(fr[0]);
        chk("sync_busy", bus.busy, 1);
        send_range(1, 7);
        chk("we_before_last_byte", bus.mem_we, 0);
        send(fr[7]);
        chk("we_after_last_byte", {bus.mem_we, bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata},
            {1'b1, 1'b0, 8'd0, 8'd0, 32'd1});
        send_range(8, 52);
        send(fr[52]);
        chk("ack_resp", {bus.tx_valid, bus.tx_data, bus.load_done, bus.err_code},
            {1'b1, 8'h06, 1'b1, 2'd0});
        idle(1);
        chk("ack_busy_fall", {bus.busy, bus.tx_valid}, 0);
        chk("ack_dims", {bus.m_dim, bus.n_dim, bus.p_dim}, {8'd2, 8'd3, 8'd2});
        chk("ack_ld_cnt", ld_cnt, 1);
        chk("wr_count", wr_log.size(), 12);
        chk("wr_A00", wr_log[0], wr(1'b0, 8'd0, 8'd0, 32'd1));
        chk("wr_A12", wr_log[5], wr(1'b0, 8'd1, 8'd2, 32'd6));
        chk("wr_B00", wr_log[6], wr(1'b1, 8'd0, 8'd0, 32'd7));
        chk("wr_B21", wr_log[11], wr(1'b1, 8'd2, 8'd1, 32'd12));

        // M = 0
        w0 = wr_log.size();
        send(8'hA5); send(8'h00); send(8'h03); send(8'h02);
        chk("m0_nak", {bus.tx_valid, bus.tx_data, bus.err_code, bus.load_done},
            {1'b1, 8'h15, 2'd1, 1'b0});
        idle(3);
        chk("m0_busy", bus.busy, 0);
        chk("m0_nowrite", wr_log.size(), w0);
        chk("err_hold", bus.err_code, 1);

        // N = MAX_N + 1
        send(8'hA5); send(8'h02); send(8'h05); send(8'h02);
        chk("n5_nak", {bus.tx_valid, bus.tx_data, bus.err_code}, {1'b1, 8'h15, 2'd1});
        idle(3);
        chk("n5_nowrite", wr_log.size(), w0);

        // checksum bit 0 flipped on a 1x2x1 frame (correct checksum would be 0x06)
        build(1, 2, 1, 8'h07);
        w0 = wr_log.size();
        l0 = ld_cnt;
        send(fr[0]);
        chk("err_clear_on_sync", bus.err_code, 0);
        send_range(1, 21);
        chk("cs_nak", {bus.tx_valid, bus.tx_data, bus.err_code, bus.load_done},
            {1'b1, 8'h15, 2'd2, 1'b0});
        idle(1);
        chk("cs_writes", wr_log.size() - w0, 4);
        chk("cs_last_write", wr_log[wr_log.size()-1], wr(1'b1, 8'd1, 8'd0, 32'd4));
        chk("cs_no_load_done", ld_cnt - l0, 0);
        chk("cs_dims_kept", {bus.m_dim, bus.n_dim, bus.p_dim}, {8'd2, 8'd3, 8'd2});

        // timeout after 5 A bytes
        build(2, 3, 2, 8'h0F);
        send_range(0, 9);
        waits = 0;
        while (!bus.tx_valid && waits < 300) begin
            @(negedge clk);
            waits++;
        end
        chk("tmo_latency", 1 + waits, 101);
        chk("tmo_resp", {bus.tx_valid, bus.tx_data, bus.err_code}, {1'b1, 8'h15, 2'd3});
        idle(2);

        // byte landing on cycle 100 keeps the frame alive
        send_range(0, 9);
        idle(99);
        chk("tmo_edge_pre", bus.tx_valid, 0);
        send(fr[9]);
        chk("tmo_edge_saved", {bus.tx_valid, bus.busy}, {1'b0, 1'b1});
        send_range(10, 53);
        chk("tmo_edge_ack", {bus.tx_valid, bus.tx_data, bus.load_done}, {1'b1, 8'h06, 1'b1});
        idle(2);

        // tx_ready held low for 7 cycles on ACK
        l0 = ld_cnt;
        bus.tx_ready = 1'b0;
        send_range(0, 53);
        stable = 1'b1;
        repeat (7) begin
            if (!(bus.tx_valid && bus.tx_data == 8'h06 && !bus.load_done && bus.busy)) stable = 1'b0;
            @(negedge clk);
        end
        chk("hold_stable", stable, 1);
        bus.tx_ready = 1'b1;
        #1;
        chk("accept_load_done", {bus.tx_valid, bus.load_done}, {1'b1, 1'b1});
        @(negedge clk);
        chk("accept_busy_fall", {bus.busy, bus.tx_valid}, 0);
        chk("accept_ld_once", ld_cnt - l0, 1);

        // reset during LOAD_B
        send_range(0, 33);
        chk("in_load_b", bus.mem_sel, 1);
        rst = 1'b1;
        idle(1);
        chk("midrst_wrport", {bus.mem_we, bus.mem_sel, bus.mem_row, bus.mem_col, bus.mem_wdata}, 64'd0);
        chk("midrst_status", {bus.m_dim, bus.n_dim, bus.p_dim, bus.busy, bus.load_done, bus.err_code,
                              bus.tx_data, bus.tx_valid}, 64'd0);
        rst = 1'b0;
        w0 = wr_log.size();
        r0 = txv_rise;
        send_range(33, 53);
        idle(150);
        chk("midrst_no_resp", txv_rise - r0, 0);
        chk("midrst_no_write", wr_log.size() - w0, 0);
        chk("midrst_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised successor to the single-format UART matrix loader. Accepts a framed byte stream from the UART receiver (one byte per `rx_valid` pulse) carrying runtime dimensions M, N, P and the contents of matrices A (MxN) and B (NxP). It assembles words of configurable width and writes them into the operand buffers through a row/column write port. The frame is validated with dimension checks, an XOR checksum and an inter-byte timeout. An ACK/NAK byte is returned on a valid/ready port feeding the UART transmitter.

## Interface
- `MAX_M`, 4, maximum rows of A (1..255)
- `MAX_N`, 4, maximum columns of A and rows of B (1..255)
- `MAX_P`, 4, maximum columns of B (1..255)
- `DATA_W`, 32, element width; must be a multiple of 8, 8..64
- `TIMEOUT_CYCLES`, 500000, idle clocks allowed between bytes inside a frame

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle
- `mem_we`  out  1  write strobe, one cycle per element
- `mem_sel`  out  1  0 = A buffer, 1 = B buffer
- `mem_row`  out  8  element row index
- `mem_col`  out  8  element column index
- `mem_wdata`  out  DATA_W  element value
- `m_dim`, `n_dim`, `p_dim`  out  8 each  dimensions of the last accepted frame
- `busy`  out  1  high from sync byte until the response byte is accepted
- `load_done`  out  1  one-cycle pulse on a successful frame
- `err_code`  out  2  0 none, 1 bad dimension, 2 checksum, 3 timeout; held until the next sync byte
- `tx_data`  out  8  response byte: 0x06 ACK, 0x15 NAK
- `tx_valid`  out  1  response available
- `tx_ready`  in  1  transmitter accepts `tx_data` when `tx_valid && tx_ready`

## Operation
- Frame layout: 0xA5 sync, then M, N, P (1 byte each), then M*N A elements row-major, then N*P B elements row-major, then 1 checksum byte.
- Each element is DATA_W/8 bytes, MSB first.
- Checksum is the XOR of every byte after sync, up to but excluding the checksum byte.
- States:
  - IDLE: ignores all bytes except 0xA5 → DIMS. On entry to DIMS, clears the checksum accumulator and `err_code`.
  - DIMS: captures M, N, P. After P: if any value is 0 or exceeds its MAX → RESP with NAK and err 1; else → LOAD_A.
  - LOAD_A: counts bytes per word. Row/col counters run col-fastest and wrap at N. After element (M-1, N-1) → LOAD_B.
  - LOAD_B: same as LOAD_A with col wrapping at P; after element (N-1, P-1) → CHECK.
  - CHECK: next byte compared with the accumulator. Match → RESP with ACK; mismatch → RESP with NAK and err 2.
  - RESP: holds `tx_valid` until the handshake completes, then → IDLE. Bytes arriving in RESP are dropped.
- Timeout: in DIMS, LOAD_A, LOAD_B and CHECK, a counter increments every cycle without `rx_valid`. When it reaches TIMEOUT_CYCLES → RESP with NAK and err 3.
- Elements written before an error remain in the buffers. Consumers act only on `load_done`.
- `m_dim`, `n_dim`, `p_dim` update only on `load_done`.

## Timing
- Reset: state IDLE; all counters 0. Every output is 0: `mem_we`, `mem_sel`, `mem_row`, `mem_col`, `mem_wdata`, all dims, `busy`, `load_done`, `err_code`, `tx_data`, `tx_valid`.
- Reset mid-frame discards the frame. No response is sent and no further writes occur.
- `mem_we` and its address/data are registered and appear exactly one cycle after the cycle carrying the element's last byte.
- `tx_valid` rises one cycle after the deciding byte: P for err 1, checksum byte for ACK/err 2. For err 3 it rises one cycle after the counter reaches TIMEOUT_CYCLES.
- `load_done` pulses in the same cycle as the ACK handshake (`tx_valid && tx_ready`).
- `busy` falls the cycle after the handshake.
- `tx_data` and `tx_valid` remain stable while `tx_ready` is low.
- `rx_valid` in the same cycle the timeout would fire: the byte wins, the counter clears and no timeout occurs.
- Back-to-back `rx_valid` on consecutive cycles is fully supported with no dropped bytes.

## Test plan
- DATA_W=32, frame M=2 N=3 P=2 with A = 1..6 and B = 7..12 plus a correct checksum → 12 writes. A(1,2)=6 appears with sel 0; B(2,1)=12 appears with sel 1. Then `tx_data`=0x06 and `load_done` pulses, with dims 2/3/2.
- Bytes 0x00, 0x11 before 0xA5 → ignored; the following frame loads normally.
- M=0 (and separately N=MAX_N+1) → no `mem_we`; NAK 0x15 one cycle after P; `err_code`=1.
- Valid frame with checksum bit 0 flipped → all elements written, then NAK, `err_code`=2, no `load_done`, dims unchanged.
- TIMEOUT_CYCLES=100, stop after 5 A bytes → NAK exactly 101 cycles after the last byte, `err_code`=3. A byte landing on cycle 100 prevents the timeout.
- `tx_ready` held low 7 cycles on ACK → `tx_data` stable, `load_done` pulses on the accept cycle. A separate run asserts `rst` during LOAD_B → all outputs return to 0 and no response is sent.
